// File: rtl/add_nibble_seq.sv
// Nibble-serial add/subtract sequencer sharing one 4-bit CLA slice.
// Optional signed saturation; start/busy/done handshake.
module adder_cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign ovfl = c[4] ^ c[3];
endmodule

module add_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  input  logic                 sat,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovfl
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] part_q;
  logic [NIBBLES-1:0][3:0] full;
  logic                    sub_q;
  logic                    sat_q;
  logic                    carry_q;
  logic [IW-1:0]           idx_q;

  logic [3:0] an;
  logic [3:0] bn;
  logic [3:0] sum_n;
  logic       co_n;
  logic       ov_n;
  logic       accept;
  logic       last;
  logic [W-1:0] sat_val;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (idx_q == LAST);
  assign an     = a_q[idx_q];
  assign bn     = sub_q ? ~b_q[idx_q] : b_q[idx_q];

  adder_cla_4bit u_cla (
    .a    (an),
    .b    (bn),
    .cin  (carry_q),
    .sum  (sum_n),
    .cout (co_n),
    .ovfl (ov_n)
  );

  // saturate toward the sign of a: positive max or negative min
  assign sat_val = {a_q[NIBBLES-1][3], {(W-1){~a_q[NIBBLES-1][3]}}};

  always_comb begin
    full = part_q;
    full[idx_q] = sum_n;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovfl    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        sat_q   <= sat;
        carry_q <= sub;
        idx_q   <= '0;
        part_q  <= '0;
        result  <= '0;
        cout    <= 1'b0;
        ovfl    <= 1'b0;
      end else if (state_q == RUN) begin
        part_q  <= full;
        carry_q <= co_n;
        if (last) begin
          cout   <= co_n;
          ovfl   <= ov_n;
          result <= (sat_q && ov_n) ? sat_val : full;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_add_nibble_seq.sv
// Directed-vector bench for add_nibble_seq (NIBBLES=4).
// Table vectors, handshake sequences, reset abort, random ops.
module tb_add_nibble_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        sat;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovfl;

  int errors = 0;
  int checks = 0;
  int both_hi = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  add_nibble_seq #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .sat    (sat),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovfl   (ovfl)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (busy && done) both_hi++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic s,
                                 input logic t);
    vec_t v;
    logic [15:0] yy;
    logic [16:0] r;
    yy = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + {16'd0, s};
    v.a = x;
    v.b = y;
    v.sub = s;
    v.sat = t;
    v.co = r[16];
    v.ov = (x[15] == yy[15]) && (r[15] != x[15]);
    v.res = r[15:0];
    if (t && v.ov) v.res = x[15] ? 16'h8000 : 16'h7FFF;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    @(negedge clk);
    start = 1'b1;
    a = v.a;
    b = v.b;
    sub = v.sub;
    sat = v.sat;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~v.a;
    b = ~v.b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " busy/done"}, {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk({tag, " done"}, {30'd0, busy, done}, 32'd1);
    chk({tag, " result"}, {16'd0, result}, {16'd0, v.res});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, v.co});
    chk({tag, " ovfl"}, {31'd0, ovfl}, {31'd0, v.ov});
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    vecs[2] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    vecs[3] = '{16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 0, 1};
    vecs[4] = '{16'h0000, 16'h0001, 1, 0, 16'hFFFF, 0, 0};
    vecs[5] = '{16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 1};
    vecs[6] = '{16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1};
    vecs[7] = '{16'h0005, 16'h0005, 1, 0, 16'h0000, 1, 0};
    vecs[8] = '{16'h8000, 16'h8000, 0, 1, 16'h8000, 1, 1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    sat = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {13'd0, busy, done, cout, ovfl, result},
        32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i], $sformatf("vec%0d", i));

    // start held through RUN with changing operands, then
    // accepted again in DONE for back-to-back operation
    @(negedge clk);
    start = 1'b1;
    a = 16'h1234;
    b = 16'h0FFF;
    sub = 1'b0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held busy", {30'd0, busy, done}, 32'd2);
      a = 16'hA5A5 + 16'(i);
      b = 16'h5A5A - 16'(i);
      sub = ~sub;
    end
    @(negedge clk);
    chk("held done", {30'd0, busy, done}, 32'd1);
    chk("held result", {16'd0, result}, 32'h2233);
    a = 16'h0001;
    b = 16'h0002;
    sub = 1'b0;
    @(negedge clk);
    chk("b2b busy", {30'd0, busy, done}, 32'd2);
    chk("b2b cleared", {16'd0, result}, 32'd0);
    start = 1'b0;
    a = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b run", {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk("b2b done", {30'd0, busy, done}, 32'd1);
    chk("b2b result", {16'd0, result}, 32'h0003);

    // reset while idx=2 aborts the operation
    @(negedge clk);
    start = 1'b1;
    a = 16'h7FFF;
    b = 16'h7FFF;
    sub = 1'b0;
    sat = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst abort", {13'd0, busy, done, cout, ovfl, result},
        32'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst idle", {13'd0, busy, done, cout, ovfl, result},
          32'd0);
    end
    do_op('{16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0}, "post");

    for (int i = 0; i < 150; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      x = 16'($urandom);
      y = 16'($urandom);
      do_op(model(x, y, 1'($urandom), 1'($urandom)),
            $sformatf("rnd%0d", i));
    end

    chk("busy&done overlap", both_hi, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
